// File: rtl/axis_skid_slice.sv
// AXI4-Stream register slice with registered tvalid/payload forward and registered tready backward.
// Optional packet counter output enabled by defining AXIS_SKID_PKT_COUNT_EN.
module axis_skid_slice #(
    parameter int N = 4,
    parameter int I = 1,
    parameter int D = 1,
    parameter int U = 1
) (
    input  logic           aclk,
    input  logic           reset,
    input  logic           s_tvalid,
    output logic           s_tready,
    input  logic [N*8-1:0] s_tdata,
    input  logic [N-1:0]   s_tkeep,
    input  logic           s_tlast,
    input  logic [I-1:0]   s_tid,
    input  logic [D-1:0]   s_tdest,
    input  logic [U-1:0]   s_tuser,
    output logic           m_tvalid,
    input  logic           m_tready,
    output logic [N*8-1:0] m_tdata,
    output logic [N-1:0]   m_tkeep,
    output logic           m_tlast,
    output logic [I-1:0]   m_tid,
    output logic [D-1:0]   m_tdest,
    output logic [U-1:0]   m_tuser
`ifdef AXIS_SKID_PKT_COUNT_EN
    ,
    output logic [31:0]    pkt_count
`endif
);

    localparam int W = N*8 + N + 1 + I + D + U;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [W-1:0] out_q;
    logic [W-1:0] skid_q;
    logic [W-1:0] s_payload;
    logic         acc;
    logic         take;
    logic         load_out_s;
    logic         load_out_skid;
    logic         load_skid;

    assign s_payload = {s_tdata, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    assign {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = out_q;

    assign acc  = s_tvalid & s_tready;
    assign take = m_tvalid & m_tready;

    always_comb begin
        state_next    = state;
        load_out_s    = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (acc) begin
                    state_next = ST_BUSY;
                    load_out_s = 1'b1;
                end
            end
            ST_BUSY: begin
                case ({acc, take})
                    2'b11: load_out_s = 1'b1;
                    2'b10: begin
                        state_next = ST_FULL;
                        load_skid  = 1'b1;
                    end
                    2'b01: state_next = ST_EMPTY;
                    default: state_next = ST_BUSY;
                endcase
            end
            ST_FULL: begin
                if (take) begin
                    state_next    = ST_BUSY;
                    load_out_skid = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Handshake flops are derived from the next state so m_tready never reaches s_tready combinationally.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            s_tready <= 1'b0;
            m_tvalid <= 1'b0;
        end else begin
            state    <= state_next;
            s_tready <= (state_next != ST_FULL);
            m_tvalid <= (state_next != ST_EMPTY);
        end
    end

    always_ff @(posedge aclk) begin
        if (load_out_s) begin
            out_q <= s_payload;
        end else if (load_out_skid) begin
            out_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= s_payload;
        end
    end

`ifdef AXIS_SKID_PKT_COUNT_EN
    always_ff @(posedge aclk) begin
        if (reset) begin
            pkt_count <= 32'd0;
        end else if (take && m_tlast) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_skid_slice.sv
// Scoreboard bench for axis_skid_slice: driver pushes accepted beats, a negedge monitor pops and compares.
// Packet counter checks are compiled only when AXIS_SKID_PKT_COUNT_EN is defined.
module tb_axis_skid_slice;

    localparam int N = 4;
    localparam int I = 1;
    localparam int D = 1;
    localparam int U = 1;
    localparam int W = N*8 + N + 1 + I + D + U;

    logic           aclk = 1'b0;
    logic           reset;
    logic           s_tvalid;
    logic           s_tready;
    logic [N*8-1:0] s_tdata;
    logic [N-1:0]   s_tkeep;
    logic           s_tlast;
    logic [I-1:0]   s_tid;
    logic [D-1:0]   s_tdest;
    logic [U-1:0]   s_tuser;
    logic           m_tvalid;
    logic           m_tready;
    logic [N*8-1:0] m_tdata;
    logic [N-1:0]   m_tkeep;
    logic           m_tlast;
    logic [I-1:0]   m_tid;
    logic [D-1:0]   m_tdest;
    logic [U-1:0]   m_tuser;
`ifdef AXIS_SKID_PKT_COUNT_EN
    logic [31:0]    pkt_count;
`endif

    logic [W-1:0]   s_beat;
    logic [W-1:0]   m_beat;
    logic [W-1:0]   sb_q[$];
    logic [W-1:0]   held;
    logic           hold_pending = 1'b0;
    int             checks = 0;
    int             failures = 0;
    int             takes = 0;

    assign {s_tdata, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser} = s_beat;
    assign m_beat = {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};

    axis_skid_slice #(.N(N), .I(I), .D(D), .U(U)) dut (
        .aclk     (aclk),
        .reset    (reset),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tid    (s_tid),
        .s_tdest  (s_tdest),
        .s_tuser  (s_tuser),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .m_tdest  (m_tdest),
        .m_tuser  (m_tuser)
`ifdef AXIS_SKID_PKT_COUNT_EN
        ,
        .pkt_count(pkt_count)
`endif
    );

    always #5 aclk = ~aclk;

    function automatic logic [W-1:0] make_beat(input logic [31:0] data, input logic [3:0] keep,
                                               input logic last, input logic [2:0] side);
        return {data, keep, last, side};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
    task automatic applyStimulus(input logic [W-1:0] beat, output int stalls);
        s_beat   = beat;
        s_tvalid = 1'b1;
        stalls   = 0;
        forever begin
            @(negedge aclk);
            if (s_tready) begin
                sb_q.push_back(beat);
                break;
            end
            stalls++;
            if (stalls > 200) begin
                checks++;
                failures++;
                $display("[TB] FAIL accept_timeout actual=stalled expected=accepted at %0t", $time);
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100; k++) begin
            if (sb_q.size() == 0) break;
            @(posedge aclk);
            #1;
        end
        checkOutput(name, 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every transfer and checks payload stability during stalls.
    initial begin
        logic [W-1:0] exp_beat;
        forever begin
            @(negedge aclk);
            if (m_tvalid) begin
                if (hold_pending) checkOutput("hold_stable", 64'(m_beat), 64'(held));
                if (m_tready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_beat actual=0x%0h expected=none at %0t", m_beat, $time);
                    end else begin
                        exp_beat = sb_q.pop_front();
                        checkOutput("sb_beat", 64'(m_beat), 64'(exp_beat));
                    end
                    takes++;
                    hold_pending = 1'b0;
                end else begin
                    hold_pending = 1'b1;
                    held = m_beat;
                end
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           stalls;
        int           takes0;
        logic [63:0]  rnd;
        logic [W-1:0] beat_a;
        logic [W-1:0] beat_b;
        logic [W-1:0] beat_c;
        bit           done;

        reset    = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        s_beat   = '0;

        // Reset behaviour and release
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        checkOutput("rst_s_tready", 64'(s_tready), 64'd0);
        checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge aclk);
        #1;
        reset = 1'b0;
        @(negedge aclk);
        checkOutput("pre_edge_s_tready", 64'(s_tready), 64'd0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        checkOutput("post_rel_s_tready", 64'(s_tready), 64'd1);
        checkOutput("post_rel_m_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge aclk);
        #1;

        // Full-rate stream of 16 beats
        $display("[TB] streaming 16 beats");
        m_tready = 1'b1;
        takes0 = takes;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(make_beat(32'(i), 4'hF, (i == 16), 3'(i)), stalls);
            checkOutput("stream_no_stall", 64'(stalls), 64'd0);
        end
        @(posedge aclk);
        #1;
        checkOutput("stream_done", 64'(sb_q.size()), 64'd0);
        checkOutput("stream_takes", 64'(takes - takes0), 64'd16);

        // Back-pressure: A in OUT, B in SKID, C held upstream
        $display("[TB] backpressure A,B,C");
        m_tready = 1'b0;
        beat_a = make_beat(32'hAAAA0001, 4'h1, 1'b0, 3'd1);
        beat_b = make_beat(32'hBBBB0002, 4'h3, 1'b0, 3'd2);
        beat_c = make_beat(32'hCCCC0003, 4'h7, 1'b1, 3'd4);
        applyStimulus(beat_a, stalls);
        applyStimulus(beat_b, stalls);
        s_beat   = beat_c;
        s_tvalid = 1'b1;
        repeat (3) begin
            @(posedge aclk);
            #1;
        end
        checkOutput("bp_s_tready", 64'(s_tready), 64'd0);
        checkOutput("bp_m_tvalid", 64'(m_tvalid), 64'd1);
        checkOutput("bp_holds_a", 64'(m_beat), 64'(beat_a));
        checkOutput("bp_queue", 64'(sb_q.size()), 64'd2);
        m_tready = 1'b1;
        applyStimulus(beat_c, stalls);
        drain("bp_drain");

        // Random handshakes
        $display("[TB] random traffic");
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        @(posedge aclk);
                        #1;
                    end
                    rnd = {$urandom(), $urandom()};
                    applyStimulus(rnd[W-1:0], stalls);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge aclk);
                    #1;
                    m_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_tready = 1'b1;
        drain("rand_drain");

        // Reset while FULL
        $display("[TB] reset while full");
        m_tready = 1'b0;
        applyStimulus(make_beat(32'h11111111, 4'hF, 1'b0, 3'd0), stalls);
        applyStimulus(make_beat(32'h22222222, 4'hF, 1'b0, 3'd0), stalls);
        checkOutput("full_s_tready", 64'(s_tready), 64'd0);
        reset = 1'b1;
        @(posedge aclk);
        #1;
        @(negedge aclk);
        checkOutput("rst_full_m_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("rst_full_s_tready", 64'(s_tready), 64'd0);
        sb_q.delete();
        @(posedge aclk);
        #1;
        reset = 1'b0;
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        takes0 = takes;
        applyStimulus(make_beat(32'hCAFEF00D, 4'hF, 1'b1, 3'd5), stalls);
        repeat (3) begin
            @(posedge aclk);
            #1;
        end
        checkOutput("after_rst_queue", 64'(sb_q.size()), 64'd0);
        checkOutput("after_rst_takes", 64'(takes - takes0), 64'd1);

`ifdef AXIS_SKID_PKT_COUNT_EN
        // Packet counter
        $display("[TB] packet counter");
        reset = 1'b1;
        @(posedge aclk);
        #1;
        reset = 1'b0;
        @(posedge aclk);
        #1;
        checkOutput("pkt_reset", 64'(pkt_count), 64'd0);
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 3; b++) begin
                applyStimulus(make_beat(32'(p * 16 + b), 4'hF, (b == 2), 3'd0), stalls);
            end
        end
        drain("pkt_drain");
        @(posedge aclk);
        #1;
        checkOutput("pkt_count_5", 64'(pkt_count), 64'd5);
        force dut.pkt_count = 32'hFFFFFFFF;
        @(posedge aclk);
        #1;
        release dut.pkt_count;
        applyStimulus(make_beat(32'h5A5A5A5A, 4'hF, 1'b1, 3'd0), stalls);
        drain("wrap_drain");
        @(posedge aclk);
        #1;
        checkOutput("pkt_count_wrap", 64'(pkt_count), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
